// File: rtl/ad9361_lvds_tx_framer.sv
// AD9361 6-bit LVDS transmit framer.
// Takes one 12-bit I/Q sample set per frame over valid/ready and emits it as
// 6-bit words with the AD9361 frame strobe, in 1R1T (4 words) or 2R2T (8 words)
// cadence. A starved load produces an IDLE_DATA frame and a counted underflow.
// Optional build macro AD9361_TX_RAMP_EN adds tx_ramp_sel, which replaces the
// sample data with a per-frame 6-bit ramp for loopback against the RX path.

module ad9361_lvds_tx_framer #(
    parameter int         UF_CNT_W  = 16,
    parameter logic [5:0] IDLE_DATA = 6'h00
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tx_enable,
    input  logic                tx_r1_mode,
`ifdef AD9361_TX_RAMP_EN
    input  logic                tx_ramp_sel,
`endif
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [11:0]         s_data_i0,
    input  logic [11:0]         s_data_q0,
    input  logic [11:0]         s_data_i1,
    input  logic [11:0]         s_data_q1,
    output logic                tx_frame,
    output logic [5:0]          tx_data,
    output logic                tx_underflow,
    output logic [UF_CNT_W-1:0] underflow_count
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t state_q, state_d;

    logic                mode_q, mode_d;
    logic [2:0]          cnt_q, cnt_d;
    logic [11:0]         i0_q, i0_d;
    logic [11:0]         q0_q, q0_d;
    logic [11:0]         i1_q, i1_d;
    logic [11:0]         q1_q, q1_d;
    logic                fill_q, fill_d;
    logic [5:0]          fill_word_q, fill_word_d;
    logic                tx_frame_q, tx_frame_d;
    logic [5:0]          tx_data_q, tx_data_d;
    logic                tx_underflow_q, tx_underflow_d;
    logic [UF_CNT_W-1:0] uf_cnt_q, uf_cnt_d;

    logic last_word;
    logic load;
    logic ramp_sel;

`ifdef AD9361_TX_RAMP_EN
    logic [5:0] ramp_q, ramp_d;
    assign ramp_sel = tx_ramp_sel;
`else
    assign ramp_sel = 1'b0;
`endif

    // Word index -> 6-bit slice. All high halves go out first, then all low
    // halves, walking I0, Q0, I1, Q1 (only I0/Q0 in 1R1T).
    function automatic logic [5:0] word_sel(
        input logic        r1,
        input logic [2:0]  idx,
        input logic [11:0] i0,
        input logic [11:0] q0,
        input logic [11:0] i1,
        input logic [11:0] q1
    );
        logic       lo;
        logic [1:0] pos;
        logic [11:0] smp;
        if (r1) begin
            lo  = idx[1];
            pos = {1'b0, idx[0]};
        end else begin
            lo  = idx[2];
            pos = idx[1:0];
        end
        case (pos)
            2'd0:    smp = i0;
            2'd1:    smp = q0;
            2'd2:    smp = i1;
            default: smp = q1;
        endcase
        return lo ? smp[5:0] : smp[11:6];
    endfunction

    // The strobe is high over the high-half words, i.e. the first half of the frame.
    function automatic logic frame_level(input logic r1, input logic [2:0] idx);
        return r1 ? ~idx[1] : ~idx[2];
    endfunction

    assign last_word = mode_q ? (cnt_q == 3'd3) : (cnt_q == 3'd7);

    // A new frame starts leaving IDLE or on the last word of a running frame;
    // a disable on that same cycle wins and nothing is loaded.
    assign load = ~rst & tx_enable &
                  ((state_q == ST_IDLE) | ((state_q == ST_RUN) & last_word));

    assign s_ready = load & ~ramp_sel;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: RUN keeps reloading while enabled, DRAIN finishes the current frame.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tx_enable) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (last_word) begin
                    state_d = tx_enable ? ST_RUN : ST_IDLE;
                end else if (!tx_enable) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (last_word) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and registered outputs: load a sample, step through its words, or idle.
    always_comb begin
        mode_d         = mode_q;
        cnt_d          = cnt_q;
        i0_d           = i0_q;
        q0_d           = q0_q;
        i1_d           = i1_q;
        q1_d           = q1_q;
        fill_d         = fill_q;
        fill_word_d    = fill_word_q;
        tx_frame_d     = 1'b0;
        tx_data_d      = IDLE_DATA;
        tx_underflow_d = 1'b0;
        uf_cnt_d       = uf_cnt_q;
`ifdef AD9361_TX_RAMP_EN
        ramp_d         = ramp_q;
`endif

        if (load) begin
            if (state_q == ST_IDLE) begin
                mode_d = tx_r1_mode;
            end
            cnt_d = 3'd0;
            i0_d  = s_data_i0;
            q0_d  = s_data_q0;
            i1_d  = s_data_i1;
            q1_d  = s_data_q1;
            if (ramp_sel) begin
`ifdef AD9361_TX_RAMP_EN
                fill_d      = 1'b1;
                fill_word_d = ramp_q;
                ramp_d      = ramp_q + 6'd1;
`endif
            end else if (!s_valid) begin
                fill_d         = 1'b1;
                fill_word_d    = IDLE_DATA;
                tx_underflow_d = 1'b1;
                if (!(&uf_cnt_q)) begin
                    uf_cnt_d = uf_cnt_q + {{(UF_CNT_W-1){1'b0}}, 1'b1};
                end
            end else begin
                fill_d = 1'b0;
            end
            tx_frame_d = 1'b1;
            tx_data_d  = fill_d ? fill_word_d : s_data_i0[11:6];
        end else if ((state_q != ST_IDLE) && !last_word) begin
            cnt_d      = cnt_q + 3'd1;
            tx_frame_d = frame_level(mode_q, cnt_d);
            tx_data_d  = fill_q ? fill_word_q
                                : word_sel(mode_q, cnt_d, i0_q, q0_q, i1_q, q1_q);
        end else begin
            cnt_d = 3'd0;
        end
    end

    // Datapath registers; reset discards any partial frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q         <= 1'b0;
            cnt_q          <= 3'd0;
            i0_q           <= 12'h000;
            q0_q           <= 12'h000;
            i1_q           <= 12'h000;
            q1_q           <= 12'h000;
            fill_q         <= 1'b0;
            fill_word_q    <= IDLE_DATA;
            tx_frame_q     <= 1'b0;
            tx_data_q      <= IDLE_DATA;
            tx_underflow_q <= 1'b0;
            uf_cnt_q       <= '0;
        end else begin
            mode_q         <= mode_d;
            cnt_q          <= cnt_d;
            i0_q           <= i0_d;
            q0_q           <= q0_d;
            i1_q           <= i1_d;
            q1_q           <= q1_d;
            fill_q         <= fill_d;
            fill_word_q    <= fill_word_d;
            tx_frame_q     <= tx_frame_d;
            tx_data_q      <= tx_data_d;
            tx_underflow_q <= tx_underflow_d;
            uf_cnt_q       <= uf_cnt_d;
        end
    end

`ifdef AD9361_TX_RAMP_EN
    // Ramp value advances once per ramp frame and wraps mod 64.
    always_ff @(posedge clk) begin
        if (rst) begin
            ramp_q <= 6'd0;
        end else begin
            ramp_q <= ramp_d;
        end
    end
`endif

    assign tx_frame        = tx_frame_q;
    assign tx_data         = tx_data_q;
    assign tx_underflow    = tx_underflow_q;
    assign underflow_count = uf_cnt_q;

endmodule

// File: tb/tb_ad9361_lvds_tx_framer.sv
// Self-checking bench for ad9361_lvds_tx_framer.
// A frame-level model (queue of pending words) predicts every output each
// cycle; directed sequences add literal expectations. A second instance with a
// 3-bit underflow counter shares the stimulus to exercise saturation.

module tb_ad9361_lvds_tx_framer;

    logic        clk;
    logic        rst;
    logic        tx_enable;
    logic        tx_r1_mode;
    logic        tx_ramp_sel;
    logic        s_valid;
    logic        s_ready;
    logic [11:0] s_data_i0, s_data_q0, s_data_i1, s_data_q1;
    logic        tx_frame;
    logic [5:0]  tx_data;
    logic        tx_underflow;
    logic [15:0] underflow_count;

    logic        sat_s_ready;
    logic        sat_tx_frame;
    logic [5:0]  sat_tx_data;
    logic        sat_tx_underflow;
    logic [2:0]  sat_underflow_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state
    int          m_state = 0;   // 0 idle, 1 run, 2 drain
    logic        m_r1 = 1'b0;
    logic [6:0]  m_q[$];        // {frame, data} still to be shown this frame
    logic [5:0]  m_ramp = 6'd0;
    int          m_count = 0;
    logic        e_ready;
    logic        e_frame = 1'b0;
    logic [5:0]  e_data = 6'h00;
    logic        e_uf = 1'b0;

    logic        obs_ready;
    logic        obs_frame;
    logic [5:0]  obs_data;

    ad9361_lvds_tx_framer #(.UF_CNT_W(16), .IDLE_DATA(6'h00)) dut (
        .clk             (clk),
        .rst             (rst),
        .tx_enable       (tx_enable),
        .tx_r1_mode      (tx_r1_mode),
`ifdef AD9361_TX_RAMP_EN
        .tx_ramp_sel     (tx_ramp_sel),
`endif
        .s_valid         (s_valid),
        .s_ready         (s_ready),
        .s_data_i0       (s_data_i0),
        .s_data_q0       (s_data_q0),
        .s_data_i1       (s_data_i1),
        .s_data_q1       (s_data_q1),
        .tx_frame        (tx_frame),
        .tx_data         (tx_data),
        .tx_underflow    (tx_underflow),
        .underflow_count (underflow_count)
    );

    ad9361_lvds_tx_framer #(.UF_CNT_W(3), .IDLE_DATA(6'h00)) dut_sat (
        .clk             (clk),
        .rst             (rst),
        .tx_enable       (tx_enable),
        .tx_r1_mode      (tx_r1_mode),
`ifdef AD9361_TX_RAMP_EN
        .tx_ramp_sel     (tx_ramp_sel),
`endif
        .s_valid         (s_valid),
        .s_ready         (sat_s_ready),
        .s_data_i0       (s_data_i0),
        .s_data_q0       (s_data_q0),
        .s_data_i1       (s_data_i1),
        .s_data_q1       (s_data_q1),
        .tx_frame        (sat_tx_frame),
        .tx_data         (sat_tx_data),
        .tx_underflow    (sat_tx_underflow),
        .underflow_count (sat_underflow_count)
    );

    // 10 ns word clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Frame-level reference: on a load, build the whole frame as a word list
    // (high halves of each channel, then low halves); otherwise pop the next word.
    task automatic modelStep();
        logic [11:0] smp [4];
        logic [5:0]  fw;
        logic        fill;
        logic        ramp_on;
        int          nch;
        e_ready = 1'b0;
        e_uf    = 1'b0;
        smp[0] = s_data_i0;
        smp[1] = s_data_q0;
        smp[2] = s_data_i1;
        smp[3] = s_data_q1;
`ifdef AD9361_TX_RAMP_EN
        ramp_on = tx_ramp_sel;
`else
        ramp_on = 1'b0;
`endif
        if (rst) begin
            m_state = 0;
            m_q.delete();
            m_count = 0;
            m_ramp  = 6'd0;
            e_frame = 1'b0;
            e_data  = 6'h00;
        end else if (m_q.size() == 0) begin
            if (tx_enable && m_state != 2) begin
                if (m_state == 0) m_r1 = tx_r1_mode;
                m_state = 1;
                nch  = m_r1 ? 2 : 4;
                fill = 1'b0;
                fw   = 6'h00;
                if (ramp_on) begin
                    fill   = 1'b1;
                    fw     = m_ramp;
                    m_ramp = m_ramp + 6'd1;
                end else begin
                    e_ready = 1'b1;
                    if (!s_valid) begin
                        fill = 1'b1;
                        e_uf = 1'b1;
                        if (m_count < 65535) m_count++;
                    end
                end
                for (int k = 0; k < nch; k++) m_q.push_back({1'b1, fill ? fw : smp[k][11:6]});
                for (int k = 0; k < nch; k++) m_q.push_back({1'b0, fill ? fw : smp[k][5:0]});
                {e_frame, e_data} = m_q.pop_front();
            end else begin
                m_state = 0;
                e_frame = 1'b0;
                e_data  = 6'h00;
            end
        end else begin
            if (m_state == 1 && !tx_enable) m_state = 2;
            {e_frame, e_data} = m_q.pop_front();
        end
    endtask

    // One word cycle: drive inputs, check s_ready, then check registered outputs after the edge.
    task automatic applyStimulus(input logic a_rst, input logic a_en, input logic a_r1,
                                 input logic a_valid, input logic [11:0] a_i0,
                                 input logic [11:0] a_q0, input logic [11:0] a_i1,
                                 input logic [11:0] a_q1, input logic a_ramp);
        int sat_exp;
        @(negedge clk);
        rst         = a_rst;
        tx_enable   = a_en;
        tx_r1_mode  = a_r1;
        s_valid     = a_valid;
        s_data_i0   = a_i0;
        s_data_q0   = a_q0;
        s_data_i1   = a_i1;
        s_data_q1   = a_q1;
        tx_ramp_sel = a_ramp;
        #1;
        modelStep();
        checkOutput("s_ready", 32'(s_ready), 32'(e_ready));
        obs_ready = s_ready;
        @(posedge clk);
        #1;
        sat_exp = (m_count > 7) ? 7 : m_count;
        checkOutput("tx_data", 32'(tx_data), 32'(e_data));
        checkOutput("tx_frame", 32'(tx_frame), 32'(e_frame));
        checkOutput("tx_underflow", 32'(tx_underflow), 32'(e_uf));
        checkOutput("underflow_count", 32'(underflow_count), 32'(m_count));
        checkOutput("sat_underflow_count", 32'(sat_underflow_count), 32'(sat_exp));
        obs_frame = tx_frame;
        obs_data  = tx_data;
    endtask

    // Directed sequences with literal pins, then randomized traffic, then the ramp check.
    initial begin
        logic [5:0] t1_words [4];
        logic       t1_frames [4];
        logic [5:0] t2_words [8];
        int         ready_seen;

        t1_words  = '{6'h2A, 6'h04, 6'h3C, 6'h23};
        t1_frames = '{1'b1, 1'b1, 1'b0, 1'b0};
        t2_words  = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h01, 6'h02, 6'h03, 6'h04};

        rst = 1'b1; tx_enable = 1'b0; tx_r1_mode = 1'b0; s_valid = 1'b0; tx_ramp_sel = 1'b0;
        s_data_i0 = '0; s_data_q0 = '0; s_data_i1 = '0; s_data_q1 = '0;

        // Reset
        for (int c = 0; c < 4; c++) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("reset_data", 32'(tx_data), 32'h0);
        checkOutput("reset_frame", 32'(tx_frame), 32'h0);

        // 1R1T single sample
        ready_seen = 0;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(0, c == 0, 1, 1, 12'hABC, 12'h123, 12'h555, 12'hAAA, 0);
            if (obs_ready) ready_seen++;
            if (c < 4) begin
                checkOutput("t1_word", 32'(obs_data), 32'(t1_words[c]));
                checkOutput("t1_frame", 32'(obs_frame), 32'(t1_frames[c]));
            end
        end
        checkOutput("t1_ready_count", 32'(ready_seen), 32'd1);
        checkOutput("t1_idle_after", 32'(obs_data), 32'h0);

        // 2R2T continuous, 100 frames
        for (int c = 0; c < 800; c++) begin
            applyStimulus(0, 1, 0, 1, 12'h001, 12'h002, 12'h003, 12'h004, 0);
            if (c < 8) checkOutput("t2_word", 32'(obs_data), 32'(t2_words[c]));
        end
        for (int c = 0; c < 9; c++) applyStimulus(0, 0, 0, 1, 12'h001, 12'h002, 12'h003, 12'h004, 0);
        checkOutput("t2_no_underflow", 32'(underflow_count), 32'd0);

        // Underflow: three starved 1R1T frames
        for (int c = 0; c < 12; c++) applyStimulus(0, 1, 1, 0, 12'hFFF, 12'hFFF, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("uf_count_3", 32'(underflow_count), 32'd3);

        // Ten more starved frames: narrow counter must stick at all-ones
        for (int c = 0; c < 40; c++) applyStimulus(0, 1, 1, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("uf_count_13", 32'(underflow_count), 32'd13);
        checkOutput("sat_count_7", 32'(sat_underflow_count), 32'd7);

        // Disable mid-frame in 2R2T; re-enable and mode change ignored until idle
        applyStimulus(0, 1, 0, 1, 12'h111, 12'h222, 12'h333, 12'h444, 0);
        applyStimulus(0, 1, 0, 1, 12'h111, 12'h222, 12'h333, 12'h444, 0);
        applyStimulus(0, 0, 0, 1, 12'h111, 12'h222, 12'h333, 12'h444, 0);
        for (int c = 0; c < 5; c++) begin
            applyStimulus(0, 1, 1, 1, 12'h111, 12'h222, 12'h333, 12'h444, 0);
            checkOutput("drain_no_ready", 32'(obs_ready), 32'd0);
        end
        applyStimulus(0, 1, 1, 1, 12'h111, 12'h222, 12'h333, 12'h444, 0);
        checkOutput("drain_idle_frame", 32'(obs_frame), 32'd0);
        checkOutput("drain_idle_data", 32'(obs_data), 32'd0);
        applyStimulus(0, 1, 1, 1, 12'h7C0, 12'h222, 12'h333, 12'h444, 0);
        checkOutput("reenable_word0", 32'(obs_data), 32'h1F);
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 1, 1, 0, 0, 0, 0, 0);
        checkOutput("reenable_r1_frame", 32'(obs_frame), 32'd0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 1, 1, 0, 0, 0, 0, 0);

        // Reset mid-frame at word 2
        applyStimulus(0, 1, 0, 1, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 0);
        applyStimulus(0, 1, 0, 1, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 0);
        applyStimulus(0, 1, 0, 1, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 0);
        checkOutput("pre_reset_word2", 32'(obs_data), 32'h3F);
        applyStimulus(1, 1, 0, 1, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 0);
        checkOutput("rst_mid_data", 32'(tx_data), 32'h0);
        checkOutput("rst_mid_frame", 32'(tx_frame), 32'h0);
        checkOutput("rst_mid_count", 32'(underflow_count), 32'h0);
        applyStimulus(1, 1, 0, 1, 12'hFFF, 12'hFFF, 12'hFFF, 12'hFFF, 0);
        checkOutput("rst_mid_ready", 32'(obs_ready), 32'h0);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            applyStimulus($urandom_range(0, 399) == 0,
                          $urandom_range(0, 99) < 85,
                          1'($urandom_range(0, 1)),
                          $urandom_range(0, 99) < 80,
                          12'($urandom), 12'($urandom), 12'($urandom), 12'($urandom),
                          $urandom_range(0, 9) == 0);
        end
        for (int c = 0; c < 9; c++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);

`ifdef AD9361_TX_RAMP_EN
        // Ramp frames in 1R1T: frame f carries f mod 64 on every word
        applyStimulus(1, 0, 1, 0, 0, 0, 0, 0, 1);
        for (int c = 0; c < 260; c++) begin
            applyStimulus(0, 1, 1, 1, 12'h5A5, 12'hA5A, 0, 0, 1);
            if ((c % 4) == 0 && ((c / 4) == 0 || (c / 4) == 1 || (c / 4) == 63 || (c / 4) == 64))
                checkOutput("ramp_word", 32'(obs_data), 32'((c / 4) % 64));
        end
        applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 1);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
